// File: rtl/switch_debouncer.sv
// Two-flop synchroniser plus per-byte debouncer for the 24 board DIP switches.
// Each 8-bit group commits as a unit once its value has held for STABLE_CYCLES clocks.
module switch_debouncer #(
    parameter int unsigned STABLE_CYCLES = 20000,
    parameter int unsigned CNT_W         = $clog2(STABLE_CYCLES)
) (
    input  logic        iCpuClock,
    input  logic        iCpuReset,
    input  logic [23:0] iFpgaSwitches,
    input  logic [2:0]  iClearChanged,
    output logic [23:0] oSwitchStable,
    output logic [2:0]  oGroupChanged,
    output logic        oAnyChanged
);

    localparam int unsigned NumGroups = 3;
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(STABLE_CYCLES - 1);

    logic [23:0]                      sync1_q, sync2_q;
    logic [23:0]                      stable_q, stable_d;
    logic [NumGroups-1:0][7:0]        cand_q, cand_d;
    logic [NumGroups-1:0][CNT_W-1:0]  cnt_q, cnt_d;
    logic [NumGroups-1:0]             commit;
    logic [NumGroups-1:0]             changed_q, changed_d;
    logic                             any_q;

    always_comb begin
        stable_d = stable_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        commit   = '0;
        for (int g = 0; g < NumGroups; g++) begin
            if (sync2_q[g*8 +: 8] == stable_q[g*8 +: 8]) begin
                // Back at the committed value: any pending count is abandoned.
                cand_d[g] = stable_q[g*8 +: 8];
                cnt_d[g]  = '0;
            end else if (sync2_q[g*8 +: 8] != cand_q[g]) begin
                cand_d[g] = sync2_q[g*8 +: 8];
                cnt_d[g]  = '0;
            end else if (cnt_q[g] != CntLast) begin
                cnt_d[g] = cnt_q[g] + 1'b1;
            end else begin
                stable_d[g*8 +: 8] = cand_q[g];
                cnt_d[g]           = '0;
                commit[g]          = 1'b1;
            end
        end
        // A commit on the same edge as a clear keeps the flag set.
        changed_d = (changed_q & ~iClearChanged) | commit;
    end

    always_ff @(posedge iCpuClock or posedge iCpuReset) begin
        if (iCpuReset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            stable_q  <= '0;
            cand_q    <= '0;
            cnt_q     <= '0;
            changed_q <= '0;
            any_q     <= 1'b0;
        end else begin
            sync1_q   <= iFpgaSwitches;
            sync2_q   <= sync1_q;
            stable_q  <= stable_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            changed_q <= changed_d;
            any_q     <= |changed_d;
        end
    end

    assign oSwitchStable = stable_q;
    assign oGroupChanged = changed_q;
    assign oAnyChanged   = any_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer with a short debounce window (STABLE_CYCLES = 4).
// A change sampled on edge k commits on edge k+6.
module tb_switch_debouncer;

    logic        clk;
    logic        rst;
    logic [23:0] sw;
    logic [2:0]  clr;
    logic [23:0] stable;
    logic [2:0]  changed;
    logic        any;

    int errors = 0;
    int checks = 0;

    switch_debouncer #(
        .STABLE_CYCLES(4)
    ) dut (
        .iCpuClock    (clk),
        .iCpuReset    (rst),
        .iFpgaSwitches(sw),
        .iClearChanged(clr),
        .oSwitchStable(stable),
        .oGroupChanged(changed),
        .oAnyChanged  (any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        sw  = 24'h0;
        clr = 3'b000;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sw  = 24'hFFFFFF;
        clr = 3'b000;
        tick();
        tick();
        tick();
        checks++;
        if (stable !== 24'h0) begin
            errors++;
            $display("FAIL reset_stable: got %h expected %h", stable, 24'h0);
        end
        checks++;
        if (changed !== 3'b000 || any !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b/%b expected 000/0", changed, any);
        end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (stable !== 24'h0) begin
            errors++;
            $display("FAIL reset_early: got %h expected %h", stable, 24'h0);
        end
        tick();
        checks++;
        if (stable !== 24'hFFFFFF) begin
            errors++;
            $display("FAIL reset_commit: got %h expected %h", stable, 24'hFFFFFF);
        end
        checks++;
        if (changed !== 3'b111 || any !== 1'b1) begin
            errors++;
            $display("FAIL reset_commit_flags: got %b/%b expected 111/1", changed, any);
        end
        clr = 3'b111;
        tick();
        clr = 3'b000;
        checks++;
        if (changed !== 3'b000 || any !== 1'b0) begin
            errors++;
            $display("FAIL reset_clear: got %b/%b expected 000/0", changed, any);
        end
    endtask

    task automatic test_clean_change();
        int early;
        apply_reset();
        sw    = 24'h0000A5;
        early = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (stable !== 24'h0 || changed !== 3'b000) early++;
        end
        checks++;
        if (early != 0) begin
            errors++;
            $display("FAIL clean_early: got %0d early updates expected 0", early);
        end
        tick();
        checks++;
        if (stable !== 24'h0000A5) begin
            errors++;
            $display("FAIL clean_value: got %h expected %h", stable, 24'h0000A5);
        end
        checks++;
        if (changed !== 3'b001 || any !== 1'b1) begin
            errors++;
            $display("FAIL clean_flags: got %b/%b expected 001/1", changed, any);
        end
    endtask

    task automatic test_bounce();
        int early;
        apply_reset();
        early = 0;
        sw = 24'h000001;
        tick();
        tick();
        if (stable !== 24'h0 || changed !== 3'b000) early++;
        sw = 24'h000000;
        tick();
        tick();
        if (stable !== 24'h0 || changed !== 3'b000) early++;
        sw = 24'h000001;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (stable !== 24'h0 || changed !== 3'b000) early++;
        end
        checks++;
        if (early != 0) begin
            errors++;
            $display("FAIL bounce_early: got %0d early updates expected 0", early);
        end
        tick();
        checks++;
        if (stable !== 24'h000001 || changed !== 3'b001) begin
            errors++;
            $display("FAIL bounce_commit: got %h/%b expected 000001/001", stable, changed);
        end
    endtask

    task automatic test_glitch();
        int bad;
        apply_reset();
        bad = 0;
        sw  = 24'h800000;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (stable !== 24'h0 || changed !== 3'b000 || any !== 1'b0) bad++;
        end
        sw = 24'h000000;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (stable !== 24'h0 || changed !== 3'b000 || any !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL glitch_abort: got %0d bad cycles expected 0", bad);
        end
    endtask

    task automatic test_collision();
        apply_reset();
        sw = 24'h005A00;
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (changed !== 3'b000) begin
            errors++;
            $display("FAIL collide_pre: got %b expected 000", changed);
        end
        clr = 3'b010;
        tick();
        checks++;
        if (stable !== 24'h005A00 || changed !== 3'b010 || any !== 1'b1) begin
            errors++;
            $display("FAIL collide_set_wins: got %h/%b/%b expected 005a00/010/1",
                     stable, changed, any);
        end
        tick();
        clr = 3'b000;
        checks++;
        if (changed !== 3'b000 || any !== 1'b0) begin
            errors++;
            $display("FAIL collide_clear: got %b/%b expected 000/0", changed, any);
        end
    endtask

    task automatic test_reset_mid_count();
        apply_reset();
        sw = 24'hFF0000;
        for (int i = 0; i < 7; i++) tick();
        checks++;
        if (stable !== 24'hFF0000 || changed !== 3'b100) begin
            errors++;
            $display("FAIL midrst_setup: got %h/%b expected ff0000/100", stable, changed);
        end
        // Five edges leave group 0 with cnt=2.
        sw = 24'hFF00FF;
        for (int i = 0; i < 5; i++) tick();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (stable !== 24'h0 || changed !== 3'b000 || any !== 1'b0) begin
            errors++;
            $display("FAIL midrst_async: got %h/%b/%b expected 000000/000/0",
                     stable, changed, any);
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (stable !== 24'h0) begin
            errors++;
            $display("FAIL midrst_early: got %h expected %h", stable, 24'h0);
        end
        tick();
        checks++;
        if (stable !== 24'hFF00FF || changed !== 3'b101 || any !== 1'b1) begin
            errors++;
            $display("FAIL midrst_commit: got %h/%b/%b expected ff00ff/101/1",
                     stable, changed, any);
        end
    endtask

    initial begin
        rst = 1'b1;
        sw  = 24'h0;
        clr = 3'b000;
        test_reset();
        test_clean_change();
        test_bounce();
        test_glitch();
        test_collision();
        test_reset_mid_count();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
